// File: rtl/usb_pkg.sv
// USB shared definitions: PID bytes, handshake/kind codes and CRC16 helpers.
package usb_pkg;

    // PID bytes as sent on the wire (upper nibble is the complement check)
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    // Handshake response codes shared with the setup handler
    typedef enum logic [1:0] {
        hs_ack   = 2'b00,
        hs_none  = 2'b01,
        hs_nak   = 2'b10,
        hs_stall = 2'b11
    } hs_code_t;

    // Transmit request kinds
    localparam logic [1:0] KIND_ACK   = 2'b00;
    localparam logic [1:0] KIND_DATA  = 2'b01;
    localparam logic [1:0] KIND_NAK   = 2'b10;
    localparam logic [1:0] KIND_STALL = 2'b11;

    // CRC16 (x^16+x^15+x^2+1), reflected form
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // PID byte for a request kind; toggle picks DATA0/DATA1
    function automatic logic [7:0] pid_byte(input logic [1:0] kind, input logic toggle);
        logic [7:0] pid;
        case (kind)
            KIND_ACK:  pid = PID_ACK;
            KIND_DATA: pid = toggle ? PID_DATA1 : PID_DATA0;
            KIND_NAK:  pid = PID_NAK;
            default:   pid = PID_STALL;
        endcase
        return pid;
    endfunction

    // One byte of CRC16, LSB first
    function automatic logic [15:0] crc16_update(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC16_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// Byte-parallel USB CRC16 register with synchronous clear and update enable.
module usb_crc16
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    // CRC accumulator; clear wins over update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC16_INIT;
        end else if (clear) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_update(crc, data);
        end
    end

endmodule

// File: rtl/usb_tx_packetizer.sv
// Control endpoint transmitter: emits handshake or DATA0/1 packets as a byte stream.
module usb_tx_packetizer
    import usb_pkg::*;
#(
    parameter int unsigned MAX_PKT = 64,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_start,
    input  logic [1:0]       tx_kind,
    input  logic             data_toggle,
    output logic             usb_send_queue_r_en,
    input  logic [7:0]       usb_send_queue_data_out,
    input  logic             usb_send_queue_empty,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_busy,
    output logic             tx_done,
    output logic [CNT_W-1:0] tx_count
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PID    = 3'd1;
    localparam logic [2:0] ST_FETCH  = 3'd2;
    localparam logic [2:0] ST_WAIT   = 3'd3;
    localparam logic [2:0] ST_DATA   = 3'd4;
    localparam logic [2:0] ST_CRC_LO = 3'd5;
    localparam logic [2:0] ST_CRC_HI = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT);

    logic [2:0]       state, state_nxt;
    logic [1:0]       kind_q, kind_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       tx_byte_nxt;
    logic             tx_valid_nxt, tx_busy_nxt, tx_done_nxt, r_en_nxt;
    logic [CNT_W-1:0] tx_count_nxt;
    logic             crc_clear, crc_en;
    logic [15:0]      crc;
    logic             accept;

    assign accept = tx_valid && tx_ready;

    usb_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clear),
        .en    (crc_en),
        .data  (usb_send_queue_data_out),
        .crc   (crc)
    );

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= ST_IDLE;
            kind_q              <= KIND_ACK;
            cnt                 <= '0;
            tx_byte             <= 8'h00;
            tx_valid            <= 1'b0;
            tx_busy             <= 1'b0;
            tx_done             <= 1'b0;
            tx_count            <= '0;
            usb_send_queue_r_en <= 1'b0;
        end else begin
            state               <= state_nxt;
            kind_q              <= kind_nxt;
            cnt                 <= cnt_nxt;
            tx_byte             <= tx_byte_nxt;
            tx_valid            <= tx_valid_nxt;
            tx_busy             <= tx_busy_nxt;
            tx_done             <= tx_done_nxt;
            tx_count            <= tx_count_nxt;
            usb_send_queue_r_en <= r_en_nxt;
        end
    end

    // Next state and next registered outputs. The pop is decided on the edge
    // that enters ST_FETCH so r_en is high during ST_FETCH and the byte lands
    // in ST_WAIT; empty cannot reassert without our own pop, so this is safe.
    always_comb begin
        state_nxt    = state;
        kind_nxt     = kind_q;
        cnt_nxt      = cnt;
        tx_byte_nxt  = tx_byte;
        tx_valid_nxt = tx_valid;
        tx_busy_nxt  = tx_busy;
        tx_done_nxt  = 1'b0;
        tx_count_nxt = tx_count;
        r_en_nxt     = 1'b0;
        crc_clear    = 1'b0;
        crc_en       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    state_nxt    = ST_PID;
                    kind_nxt     = tx_kind;
                    tx_byte_nxt  = pid_byte(tx_kind, data_toggle);
                    tx_valid_nxt = 1'b1;
                    tx_busy_nxt  = 1'b1;
                end
            end
            ST_PID: begin
                if (accept) begin
                    tx_valid_nxt = 1'b0;
                    if (kind_q == KIND_DATA) begin
                        cnt_nxt   = '0;
                        crc_clear = 1'b1;
                        r_en_nxt  = !usb_send_queue_empty;
                        state_nxt = ST_FETCH;
                    end else begin
                        tx_done_nxt  = 1'b1;
                        tx_busy_nxt  = 1'b0;
                        tx_count_nxt = cnt;
                        state_nxt    = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (usb_send_queue_r_en) begin
                    state_nxt = ST_WAIT;
                end else begin
                    tx_byte_nxt  = ~crc[7:0];
                    tx_valid_nxt = 1'b1;
                    state_nxt    = ST_CRC_LO;
                end
            end
            ST_WAIT: begin
                tx_byte_nxt  = usb_send_queue_data_out;
                tx_valid_nxt = 1'b1;
                crc_en       = 1'b1;
                cnt_nxt      = cnt + CNT_W'(1);
                state_nxt    = ST_DATA;
            end
            ST_DATA: begin
                if (accept) begin
                    tx_valid_nxt = 1'b0;
                    r_en_nxt     = (cnt != CNT_MAX) && !usb_send_queue_empty;
                    state_nxt    = ST_FETCH;
                end
            end
            ST_CRC_LO: begin
                if (accept) begin
                    tx_byte_nxt = ~crc[15:8];
                    state_nxt   = ST_CRC_HI;
                end
            end
            ST_CRC_HI: begin
                if (accept) begin
                    tx_valid_nxt = 1'b0;
                    tx_done_nxt  = 1'b1;
                    tx_busy_nxt  = 1'b0;
                    tx_count_nxt = cnt;
                    state_nxt    = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/usb_tx_packetizer.md
Name: usb_tx_packetizer

Overview:
- Device-side USB packet transmitter: the reader end of the control endpoint send queue.
- On request, emits either a handshake packet (ACK/NAK/STALL) or a DATA0/DATA1 packet as a byte stream to the bit-level serializer (NRZI/bit-stuff/SYNC/EOP live downstream).
- A data packet carries: PID byte, up to MAX_PKT payload bytes drained from the send queue, then CRC16.

Parameters:
MAX_PKT, 64, max payload bytes per data packet (8..255)
CNT_W, 8, width of byte counter / tx_count

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
tx_start  in  1  single-cycle request; sampled only in ST_IDLE
tx_kind  in  2  00 ACK, 01 DATA, 10 NAK, 11 STALL (sampled with tx_start)
data_toggle  in  1  0 selects DATA0, 1 selects DATA1 (sampled with tx_start)
usb_send_queue_r_en  out  1  queue pop; data valid on usb_send_queue_data_out the following cycle
usb_send_queue_data_out  in  8  queue read data
usb_send_queue_empty  in  1  queue empty flag
tx_byte  out  8  byte to serializer
tx_valid  out  1  tx_byte valid
tx_ready  in  1  serializer accepts byte when tx_valid && tx_ready
tx_busy  out  1  high from accepted tx_start until tx_done
tx_done  out  1  one-cycle pulse after last byte accepted
tx_count  out  CNT_W  payload bytes sent in the last data packet (held until next start)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state ST_IDLE, CRC register 16'hFFFF. The queue is not rewound; any popped byte is lost.
- PID bytes (check nibble = ~PID, sent LSB first): DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E.
- Handshake rule: tx_byte is held stable while tx_valid && !tx_ready. tx_valid never drops before acceptance.
- States:
  - ST_IDLE: on tx_start go to ST_PID; tx_busy=1 next cycle; latch kind and toggle.
  - ST_PID: present PID. On accept: if handshake kind → ST_DONE; if DATA → clear counter, CRC=FFFF, go to ST_FETCH.
  - ST_FETCH: if counter==MAX_PKT or usb_send_queue_empty → ST_CRC_LO. Otherwise pulse r_en for exactly one cycle → ST_WAIT.
  - ST_WAIT: capture data_out into tx_byte, update CRC, counter+1 → ST_DATA.
  - ST_DATA: present byte. On accept → ST_FETCH.
  - ST_CRC_LO: present ~crc[7:0]. On accept → ST_CRC_HI.
  - ST_CRC_HI: present ~crc[15:8]. On accept → ST_DONE.
  - ST_DONE: tx_done=1 for one cycle, tx_busy=0, tx_count=counter → ST_IDLE.
- CRC16: USB polynomial x^16+x^15+x^2+1, reflected (A001), init FFFF, bytewise LSB-first update, complemented on output, low byte first.
- Queue empty on the first fetch yields a zero-length packet (PID, 00, 00). Empty mid-packet ends the packet short; this is the normal short-packet termination.
- counter == MAX_PKT ends the packet even if the queue is non-empty; the remainder stays queued for the next DATA request.
- tx_start while tx_busy: ignored, no state change.
- Never asserts r_en when usb_send_queue_empty=1. At most one r_en per payload byte.
- Latency: PID presented 1 cycle after tx_start. With tx_ready tied high, a data packet of N bytes completes in 3 + 3N + 2 cycles.

Decomposition:
- Shared package usb_pkg: PID byte constants; handshake codes (hs_ack 00, hs_none 01, hs_nak 10, hs_stall 11); tx_kind encodings; CRC16 poly/init constants. Shared with the setup handler and the receive path.
- One sub-module: usb_crc16 (8-bit parallel update, clear, enable), reusable by the receive-side CRC checker.

Test Plan:
- kind=ACK, tx_ready=1 → single byte D2, tx_done one cycle later, r_en never asserted. Repeat for NAK → 5A, STALL → 1E.
- kind=DATA, toggle=1, queue empty → bytes 4B 00 00, tx_count=0.
- kind=DATA, toggle=0, queue holds 12 01 00 02 (bytes of a device-descriptor header) → C3 12 01 00 02 + CRC matching a bit-serial reference model, tx_count=4, queue empty after.
- MAX_PKT=8, queue holds 18 bytes, three DATA requests with alternating toggle → payloads of 8, 8, 2; third tx_count=2.
- Random tx_ready back-pressure (~50%) on a 10-byte packet → tx_byte stable while stalled; byte sequence identical to the no-stall run.
- rst_n asserted mid-payload (byte 3 of 8) → outputs 0 immediately; after release, tx_start DATA sends the remaining 5 queued bytes with a fresh CRC. Also: tx_start while busy is ignored.
